// File: rtl/alu_pkg.sv
// Shared opcode and controller-state types for the sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_SRL  = 3'd3,
        ALU_SRA  = 3'd4,
        ALU_BEQ  = 3'd5,
        ALU_PASS = 3'd6,
        ALU_MUL  = 3'd7
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: loads on start, retires one multiplier bit per
// cycle, and raises done for one cycle once all REG_WIDTH bits are consumed.
module alu_mul_iter #(
    parameter int REG_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [REG_WIDTH-1:0]   a,
    input  logic [REG_WIDTH-1:0]   b,
    output logic                   done,
    output logic [2*REG_WIDTH-1:0] product
);

    localparam int CW = $clog2(REG_WIDTH + 1);

    logic [REG_WIDTH-1:0]   mcand;
    logic [2*REG_WIDTH-1:0] acc;
    logic [CW-1:0]          count;
    logic                   running;
    logic [REG_WIDTH:0]     sum;

    // Upper half accumulates partial sums; lower half holds unconsumed multiplier bits.
    assign sum = {1'b0, acc[2*REG_WIDTH-1:REG_WIDTH]}
               + (acc[0] ? {1'b0, mcand} : {(REG_WIDTH+1){1'b0}});

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            acc     <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= a;
            acc     <= {{REG_WIDTH{1'b0}}, b};
            count   <= CW'(REG_WIDTH);
            running <= 1'b1;
        end else if (running) begin
            if (count != '0) begin
                acc   <= {sum, acc[REG_WIDTH-1:1]};
                count <= count - 1'b1;
            end else begin
                running <= 1'b0;
            end
        end
    end

    assign done    = running && (count == '0);
    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; single-cycle ops complete in one
// edge, MUL is delegated to the iterative multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = 8,
    parameter int OP_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] ra_in,
    input  logic [REG_WIDTH-1:0] rb_in,
    input  logic [OP_WIDTH-1:0]  op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] res_out,
    output logic [REG_WIDTH-1:0] car_out,
    output logic                 zero,
    output logic                 jump,
    output logic                 busy
);

    alu_state_e             state, state_n;
    alu_op_e                op_code;
    logic                   op_undef;
    logic                   is_mul;
    logic                   accept;
    logic                   mul_done;
    logic [2*REG_WIDTH-1:0] mul_prod;
    logic [2*REG_WIDTH-1:0] shift_val;
    logic [REG_WIDTH:0]     add_val;
    logic [REG_WIDTH-1:0]   res_n, car_n;
    logic                   jump_n;

    assign op_code  = alu_op_e'(op[2:0]);
    assign op_undef = (op >> 3) != '0;
    assign is_mul   = !op_undef && (op_code == ALU_MUL);

    assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == MUL);
    assign zero     = (res_out == '0);

    alu_mul_iter #(.REG_WIDTH(REG_WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (ra_in),
        .b       (rb_in),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign add_val = {1'b0, ra_in} + {1'b0, rb_in};

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        res_n     = '0;
        car_n     = '0;
        jump_n    = 1'b0;
        shift_val = '0;
        if (!op_undef) begin
            case (op_code)
                ALU_AND:  res_n = ra_in & rb_in;
                ALU_OR:   res_n = ra_in | rb_in;
                ALU_ADD: begin
                    res_n = add_val[REG_WIDTH-1:0];
                    car_n = {{(REG_WIDTH-1){1'b0}}, add_val[REG_WIDTH]};
                end
                ALU_SRL: begin
                    shift_val = {ra_in, {REG_WIDTH{1'b0}}} >> rb_in;
                    {res_n, car_n} = shift_val;
                end
                ALU_SRA: begin
                    shift_val = $signed({ra_in, {REG_WIDTH{1'b0}}}) >>> rb_in;
                    {res_n, car_n} = shift_val;
                end
                ALU_BEQ: begin
                    res_n  = ra_in ^ rb_in;
                    jump_n = (ra_in == rb_in);
                end
                ALU_PASS: res_n = ra_in;
                default:  res_n = '0;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept && is_mul) state_n = MUL;
            MUL:     if (mul_done)         state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Result registers change only on a completed op; otherwise they hold,
    // which keeps them frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res_out   <= '0;
            car_out   <= '0;
            jump      <= 1'b0;
        end else begin
            state <= state_n;
            if (state == MUL && mul_done) begin
                res_out   <= mul_prod[REG_WIDTH-1:0];
                car_out   <= mul_prod[2*REG_WIDTH-1:REG_WIDTH];
                jump      <= 1'b0;
                out_valid <= 1'b1;
            end else if (accept && !is_mul) begin
                res_out   <= res_n;
                car_out   <= car_n;
                jump      <= jump_n;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with hand-computed expected values.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ra_in, rb_in;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res_out, car_out;
    logic       zero, jump, busy;

    int total = 0;
    int bad   = 0;

    alu_seq #(.REG_WIDTH(8), .OP_WIDTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ra_in     (ra_in),
        .rb_in     (rb_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_out   (res_out),
        .car_out   (car_out),
        .zero      (zero),
        .jump      (jump),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        op    = o;
        ra_in = a;
        rb_in = b;
    endtask

    task automatic check_res(input string tag, input logic [7:0] r, input logic [7:0] c,
                             input logic z, input logic j);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".res"},   32'(res_out),   32'(r));
        check({tag, ".car"},   32'(car_out),   32'(c));
        check({tag, ".zero"},  32'(zero),      32'(z));
        check({tag, ".jump"},  32'(jump),      32'(j));
    endtask

    // Single op with the consumer always ready: offer for one edge, then check.
    task automatic one_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] r, input logic [7:0] c,
                          input logic z, input logic j);
        drive(o, a, b);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_res(tag, r, c, z, j);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(3'd0, 8'h00, 8'h00);
        tick();
        tick();
        check("rst.in_ready",  32'(in_ready),  32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.res",       32'(res_out),   32'd0);
        check("rst.car",       32'(car_out),   32'd0);
        check("rst.zero",      32'(zero),      32'd1);
        check("rst.jump",      32'(jump),      32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        reset = 1'b0;
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);

        one_op("add_7f_01", 3'd2, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0);
        one_op("add_ff_01", 3'd2, 8'hFF, 8'h01, 8'h00, 8'h01, 1'b1, 1'b0);
        one_op("sra_96_3",  3'd4, 8'h96, 8'd3,  8'hF2, 8'hC0, 1'b0, 1'b0);
        one_op("srl_96_3",  3'd3, 8'h96, 8'd3,  8'h12, 8'hC0, 1'b0, 1'b0);
        one_op("srl_96_20", 3'd3, 8'h96, 8'd20, 8'h00, 8'h00, 1'b1, 1'b0);
        one_op("sra_96_20", 3'd4, 8'h96, 8'd20, 8'hFF, 8'hFF, 1'b0, 1'b0);
        one_op("beq_eq",    3'd5, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b1);
        one_op("beq_ne",    3'd5, 8'h5A, 8'h5B, 8'h01, 8'h00, 1'b0, 1'b0);
        one_op("pass_a5",   3'd6, 8'hA5, 8'h3C, 8'hA5, 8'h00, 1'b0, 1'b0);
        tick();
        check("drain.out_valid", 32'(out_valid), 32'd0);

        // Back-to-back single-cycle ops: one result per edge.
        in_valid = 1'b1;
        drive(3'd0, 8'hF0, 8'h3C);
        tick();
        check_res("b2b_and", 8'h30, 8'h00, 1'b0, 1'b0);
        drive(3'd1, 8'hF0, 8'h3C);
        tick();
        check_res("b2b_or", 8'hFC, 8'h00, 1'b0, 1'b0);
        drive(3'd2, 8'hF0, 8'h3C);
        tick();
        check_res("b2b_add", 8'h2C, 8'h01, 1'b0, 1'b0);

        // Consumer stalls for three cycles with a new op on offer.
        out_ready = 1'b0;
        drive(3'd6, 8'h77, 8'h00);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall.in_ready", 32'(in_ready), 32'd0);
            tick();
            check_res("stall", 8'h2C, 8'h01, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("unstall.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_res("unstall_pass", 8'h77, 8'h00, 1'b0, 1'b0);
        tick();
        check("unstall.drain", 32'(out_valid), 32'd0);

        // MUL FF*FF = FE01, result 9 edges after acceptance.
        drive(3'd7, 8'hFF, 8'hFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check("mul.busy",      32'(busy),      32'd1);
            check("mul.in_ready",  32'(in_ready),  32'd0);
            check("mul.out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        check("mul.edge8_valid", 32'(out_valid), 32'd0);
        tick();
        check_res("mul_ff_ff", 8'h01, 8'hFE, 1'b0, 1'b0);
        check("mul.done_busy", 32'(busy), 32'd0);
        tick();
        check("mul.drain", 32'(out_valid), 32'd0);

        // Reset four cycles into a MUL aborts it silently.
        drive(3'd7, 8'h12, 8'h34);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("abort.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort.busy",  32'(busy),    32'd0);
        check("abort.res",   32'(res_out), 32'd0);
        check("abort.car",   32'(car_out), 32'd0);
        check("abort.zero",  32'(zero),    32'd1);
        check("abort.jump",  32'(jump),    32'd0);
        for (int i = 0; i < 10; i++) begin
            check("abort.no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        one_op("abort_add", 3'd2, 8'h05, 8'h03, 8'h08, 8'h00, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
